// File: rtl/core_pkg.sv
// Shared core definitions: instruction width, default reset PC, NOP encoding
// and the fetch buffer payload layout.
package core_pkg;

    localparam int          INST_W           = 32;
    localparam int          FETCH_W          = 2 * INST_W;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;

    // Fetch addresses are always word aligned; low byte-offset bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction/PC buffer. The payload is {pc, inst}.
// Flush takes priority over push and pop.
module fetch_fifo
    import core_pkg::*;
#(
    parameter int W = FETCH_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head  = mem[rd_ptr];
    assign count = cnt;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues reads to a synchronous instruction memory
// and buffers up to two instructions for decode. Redirects flush everything.
// Optional build macro INST_FETCH_PERF_EN adds the perf_fetch_cnt counter.
module inst_fetch
    import core_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rstn,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [31:0]       out_pc
`ifdef INST_FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt
`endif
);

    logic [31:0]        pc;
    logic               inflight;
    logic [31:0]        inflight_pc;
    logic [1:0]         count;
    logic [FETCH_W-1:0] head;
    logic               pop;
    logic [2:0]         occupancy;
    logic               issue;

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid & out_ready;
    // pop implies count >= 1, so this never underflows
    assign occupancy = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    assign issue     = rstn & ~redirect_valid & (occupancy < 3'd2);

    assign mem_en   = issue;
    assign mem_addr = pc[ADDR_W+1:2];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            pc       <= align_pc(redirect_pc);
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc          <= pc + 32'd4;
                inflight_pc <= pc;
            end
        end
    end

    fetch_fifo #(.W(FETCH_W)) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (redirect_valid),
        .push      (inflight & ~redirect_valid),
        .push_data ({inflight_pc, mem_rdata}),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign out_pc   = head[FETCH_W-1:INST_W];
    assign out_inst = head[INST_W-1:0];

`ifdef INST_FETCH_PERF_EN
    // Counts every accepted transfer, including one coincident with a redirect.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_fetch_cnt <= '0;
        end else if (pop) begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus random
// ready/redirect traffic against a queue-based reference model.
module tb_inst_fetch;
    import core_pkg::*;

    localparam int          ADDR_W = 10;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic              redirect_valid = 1'b0;
    logic [31:0]       redirect_pc = 32'h0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_inst;
    logic [31:0]       out_pc;
`ifdef INST_FETCH_PERF_EN
    logic [31:0]       perf_fetch_cnt;
`endif

    always #5 clk = ~clk;

    inst_fetch #(.ADDR_W(ADDR_W), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc)
`ifdef INST_FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt)
`endif
    );

    // Synchronous memory whose word k holds the value k.
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= 32'(mem_addr);
    end

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc_n = 0;
    int          iss[$];
    logic [31:0] exp_out_pc = RST_PC;
    logic [31:0] exp_issue_pc = RST_PC;
    int          exp_perf = 0;
    logic        saw_wrap = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Apply inputs for the current cycle, check outputs, advance the model.
    task automatic eval(input logic rv, input logic [31:0] rpc, input logic rdy);
        logic exp_valid;
        logic exp_en;
        logic xfer;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #1;
        exp_valid = (iss.size() > 0) && (iss[0] <= cyc_n - 2);
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("out_pc", out_pc, exp_out_pc);
            check("out_inst", out_inst, 32'(exp_out_pc[ADDR_W+1:2]));
            if (out_pc == 32'h0000_1000) saw_wrap = 1'b1;
        end
        xfer   = exp_valid & rdy;
        exp_en = !rv && ((iss.size() - (xfer ? 1 : 0)) < 2);
        check("mem_en", 32'(mem_en), 32'(exp_en));
        if (exp_en) check("mem_addr", 32'(mem_addr), 32'(exp_issue_pc[ADDR_W+1:2]));
`ifdef INST_FETCH_PERF_EN
        check("perf_cnt", perf_fetch_cnt, 32'(exp_perf));
`endif
        if (xfer) begin
            exp_perf++;
            void'(iss.pop_front());
            exp_out_pc = exp_out_pc + 32'd4;
        end
        if (rv) begin
            iss.delete();
            exp_out_pc   = {rpc[31:2], 2'b00};
            exp_issue_pc = {rpc[31:2], 2'b00};
        end else if (exp_en) begin
            iss.push_back(cyc_n);
            exp_issue_pc = exp_issue_pc + 32'd4;
        end
        cyc_n++;
    endtask

    task automatic cyc(input logic rv, input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        eval(rv, rpc, rdy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn           = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
`ifdef INST_FETCH_PERF_EN
        check("rst_perf_cnt", perf_fetch_cnt, 32'd0);
`endif
        repeat (2) @(negedge clk);
        check("rst_hold_mem_en", 32'(mem_en), 32'd0);
        iss.delete();
        exp_out_pc   = RST_PC;
        exp_issue_pc = RST_PC;
        exp_perf     = 0;
        rstn         = 1'b1;
        eval(1'b0, 32'h0, 1'b1);
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(($urandom % 16) == 0, $urandom, ($urandom % 4) != 0);
        end
    endtask

    initial begin
        do_reset();
        repeat (20) cyc(1'b0, 32'h0, 1'b1);

        // Decode stall, then release
        repeat (5) cyc(1'b0, 32'h0, 1'b0);
        repeat (6) cyc(1'b0, 32'h0, 1'b1);

        // Redirect while the buffer is full
        repeat (4) cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b1, 32'h0000_0100, 1'b0);
        repeat (4) cyc(1'b0, 32'h0, 1'b1);

        // Misaligned target, redirect coincident with a pop, back-to-back redirects
        cyc(1'b1, 32'h0000_0102, 1'b1);
        repeat (4) cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b1, 32'h0000_0200, 1'b1);
        repeat (4) cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b1, 32'h0000_0300, 1'b1);
        cyc(1'b1, 32'h0000_0400, 1'b1);
        repeat (4) cyc(1'b0, 32'h0, 1'b1);

        // Word address wraps past the top of the memory
        saw_wrap = 1'b0;
        cyc(1'b1, 32'h0000_0FF8, 1'b1);
        repeat (6) cyc(1'b0, 32'h0, 1'b1);
        check("addr_wrap_seen", 32'(saw_wrap), 32'd1);

        rand_cycles(300);

        // Reset in the middle of traffic
        do_reset();
        repeat (10) cyc(1'b0, 32'h0, 1'b1);
        rand_cycles(200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
